// File: rtl/sevseg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Optional dimming is enabled by SEVSEG_DIM_EN in the top level.
package sevseg_pkg;

    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam int         DIGITS_MAX = 8;

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_e;

    // Entry n holds segments g..a (active high) for hex digit n
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/sevseg_scan_driver_if.sv
// Load port of the 7-segment scan driver: display data plus valid/ready.
// Shared by the driver (slave) and whatever produces display values (master).
interface sevseg_scan_driver_if #(
    parameter int DIGITS = 4
) ();

    logic [4*DIGITS-1:0] value_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load_valid;
    logic                load_ready;

    modport master (
        output value_in,
        output dp_in,
        output blank_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  value_in,
        input  dp_in,
        input  blank_in,
        input  load_valid,
        output load_ready
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high a..g segment decoder.
// Bit 0 is segment a, bit 6 is segment g.
module seg_hex_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/sevseg_scan_driver.sv
// Multiplexed 7-segment scan driver with dead-time blanking and frame-synchronous commit.
// Define SEVSEG_DIM_EN to add the 4-bit brightness port (PWM duty in sixteenths).
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    sevseg_scan_driver_if.slave load,
`ifdef SEVSEG_DIM_EN
    input  logic [3:0]          brightness,
`endif
    output logic                frame_start,
    output logic [7:0]          io_seg,
    output logic [DIGITS-1:0]   io_sel
);

    localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (BLANK_TICKS >= TICKS_PER_DIGIT || BLANK_TICKS < 0) begin : g_bad_blank
        $error("sevseg_scan_driver: BLANK_TICKS must be below TICKS_PER_DIGIT");
    end
    if (DIGITS < 1 || DIGITS > DIGITS_MAX) begin : g_bad_digits
        $error("sevseg_scan_driver: DIGITS must be 1..8");
    end

    logic [CW-1:0]       cnt;
    logic [DW-1:0]       digit;

    logic                pend_full;
    logic [4*DIGITS-1:0] pend_value;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_blank;

    logic [4*DIGITS-1:0] disp_value;
    logic [DIGITS-1:0]   disp_dp;
    logic [DIGITS-1:0]   disp_blank;

    phase_e              phase;
    logic                cnt_wrap;
    logic                last_digit;
    logic                capture;
    logic                commit;
    logic                lit;
    logic [3:0]          nib;
    logic [6:0]          hex;
    logic [7:0]          seg_nxt;
    logic [DIGITS-1:0]   sel_nxt;

    assign cnt_wrap   = (cnt == CW'(TICKS_PER_DIGIT - 1));
    assign last_digit = (digit == DW'(DIGITS - 1));
    // ready is simply "pending empty", so capture and commit are exclusive
    assign capture    = load.load_valid && !pend_full;
    assign commit     = pend_full && cnt_wrap && last_digit;

    assign load.load_ready = !pend_full;

    assign nib = disp_value[{digit, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nib (nib),
        .seg (hex)
    );

`ifdef SEVSEG_DIM_EN
    logic [CW+3:0] on_off;
    assign on_off = {4'b0, cnt} - (CW+4)'(BLANK_TICKS);
    assign lit    = (on_off[3:0] < brightness);
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        phase   = (cnt < CW'(BLANK_TICKS)) ? PH_BLANK : PH_ON;
        sel_nxt = '1;
        seg_nxt = SEG_OFF;
        unique case (phase)
            PH_BLANK: ;
            PH_ON: begin
                sel_nxt[digit] = 1'b0;
                if (!disp_blank[digit] && lit) begin
                    seg_nxt = {~disp_dp[digit], ~hex};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            digit       <= '0;
            pend_full   <= 1'b0;
            pend_value  <= '0;
            pend_dp     <= '0;
            pend_blank  <= '1;
            disp_value  <= '0;
            disp_dp     <= '0;
            disp_blank  <= '1;
            io_seg      <= SEG_OFF;
            io_sel      <= '1;
            frame_start <= 1'b0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) begin
                digit <= last_digit ? '0 : digit + 1'b1;
            end

            if (capture) begin
                pend_value <= load.value_in;
                pend_dp    <= load.dp_in;
                pend_blank <= load.blank_in;
                pend_full  <= 1'b1;
            end else if (commit) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
                pend_full  <= 1'b0;
            end

            // Pins lag the counter state by one cycle
            io_seg      <= seg_nxt;
            io_sel      <= sel_nxt;
            frame_start <= (digit == '0) && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed bench for sevseg_scan_driver (DIGITS=4).
// With SEVSEG_DIM_EN the slot is 40 ticks with 8 blank ticks and dimming is exercised.
module tb_sevseg_scan_driver;

`ifdef SEVSEG_DIM_EN
    localparam int T = 40;
    localparam int B = 8;
`else
    localparam int T = 8;
    localparam int B = 2;
`endif
    localparam int FR = 4 * T;

    logic        clk;
    logic        rst_n;
    logic [3:0]  bright;
    logic        frame_start;
    logic [7:0]  io_seg;
    logic [3:0]  io_sel;
    logic [12:0] pins;

    int pos;
    int n_checks;
    int n_fail;

    sevseg_scan_driver_if #(.DIGITS(4)) lif ();

    sevseg_scan_driver #(
        .DIGITS          (4),
        .TICKS_PER_DIGIT (T),
        .BLANK_TICKS     (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (lif),
`ifdef SEVSEG_DIM_EN
        .brightness  (bright),
`endif
        .frame_start (frame_start),
        .io_seg      (io_seg),
        .io_sel      (io_sel)
    );

    assign pins = {frame_start, io_sel, io_seg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {frame_start, io_sel, io_seg} at scan position p;
    // segs holds the expected lit pattern of digit d in byte d.
    function automatic logic [12:0] exp_pins(input int p, input logic [31:0] segs,
                                             input logic [3:0] bl);
        int c;
        int d;
        logic [3:0] sel;
        logic [7:0] seg;
        logic on_lit;
        c = p % T;
        d = (p / T) % 4;
        sel = 4'hF;
        seg = 8'hFF;
        on_lit = 1'b1;
`ifdef SEVSEG_DIM_EN
        on_lit = (((c - B) % 16) < int'(bright));
`endif
        if (c >= B) begin
            sel[d] = 1'b0;
            if (!bl[d] && on_lit) seg = segs[d*8 +: 8];
        end
        return {(p % FR) == 0, sel, seg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic wait_pos(input int p);
        while (pos < p) tick();
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] dp,
                              input logic [3:0] bl);
        lif.value_in   = v;
        lif.dp_in      = dp;
        lif.blank_in   = bl;
        lif.load_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({lif.load_ready, pins} !== {1'b1, 1'b0, 4'hF, 8'hFF}) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i,
                         {lif.load_ready, pins}, {1'b1, 1'b0, 4'hF, 8'hFF});
            end
        end
        rst_n = 1'b1;
        pos = -1;
        #1;
        n_checks++;
        if ({lif.load_ready, pins} !== {1'b1, 1'b0, 4'hF, 8'hFF}) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h",
                     {lif.load_ready, pins}, {1'b1, 1'b0, 4'hF, 8'hFF});
        end
        tick();
        n_checks++;
        if ({lif.load_ready, pins} !== {1'b1, 1'b1, 4'hF, 8'hFF}) begin
            n_fail++;
            $display("FAIL first_frame_start: got %h want %h",
                     {lif.load_ready, pins}, {1'b1, 1'b1, 4'hF, 8'hFF});
        end
    endtask

    task automatic test_load();
        drive_load(16'h4321, 4'h0, 4'h0);
        tick();
        lif.load_valid = 1'b0;
        n_checks++;
        if (lif.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ready_drop: got %b want 0", lif.load_ready);
        end
        wait_pos(T + B);
        n_checks++;
        if (pins !== exp_pins(pos, 32'h0, 4'hF)) begin
            n_fail++;
            $display("FAIL pre_commit_dark: got %h want %h", pins, exp_pins(pos, 32'h0, 4'hF));
        end
        wait_pos(FR - 2);
        n_checks++;
        if (lif.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_commit: got %b want 0", lif.load_ready);
        end
        tick();
        n_checks++;
        if (lif.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_commit: got %b want 1", lif.load_ready);
        end
        for (int i = 0; i < FR; i++) begin
            tick();
            n_checks++;
            if (pins !== exp_pins(pos, 32'h99B0A4F9, 4'h0)) begin
                n_fail++;
                $display("FAIL frame_4321 pos %0d: got %h want %h", pos, pins,
                         exp_pins(pos, 32'h99B0A4F9, 4'h0));
            end
        end
    endtask

    task automatic test_midframe();
        wait_pos(2*FR + T + B + 2);
        drive_load(16'h00A5, 4'h0, 4'h0);
        tick();
        n_checks++;
        if (lif.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ready_drop: got %b want 0", lif.load_ready);
        end
        drive_load(16'hFFFF, 4'hF, 4'h0);
        for (int i = 0; i < 3; i++) tick();
        lif.load_valid = 1'b0;
        wait_pos(2*FR + 3*T + B + 1);
        n_checks++;
        if (pins !== exp_pins(pos, 32'h99B0A4F9, 4'h0)) begin
            n_fail++;
            $display("FAIL mid_no_tear: got %h want %h", pins,
                     exp_pins(pos, 32'h99B0A4F9, 4'h0));
        end
        wait_pos(3*FR - 1);
        n_checks++;
        if (lif.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ready_restore: got %b want 1", lif.load_ready);
        end
        for (int i = 0; i < FR; i++) begin
            tick();
            n_checks++;
            if (pins !== exp_pins(pos, 32'hC0C08892, 4'h0)) begin
                n_fail++;
                $display("FAIL frame_00a5 pos %0d: got %h want %h", pos, pins,
                         exp_pins(pos, 32'hC0C08892, 4'h0));
            end
        end
        n_checks++;
        if (lif.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dropped_load_stays_empty: got %b want 1", lif.load_ready);
        end
    endtask

    task automatic test_blank_dp();
        drive_load(16'h8888, 4'b0001, 4'b0100);
        tick();
        lif.load_valid = 1'b0;
        wait_pos(5*FR - 1);
        for (int i = 0; i < FR; i++) begin
            tick();
            n_checks++;
            if (pins !== exp_pins(pos, 32'h80808000, 4'b0100)) begin
                n_fail++;
                $display("FAIL frame_blank_dp pos %0d: got %h want %h", pos, pins,
                         exp_pins(pos, 32'h80808000, 4'b0100));
            end
        end
    endtask

    task automatic test_reset_midscan();
        drive_load(16'h1234, 4'h0, 4'h0);
        tick();
        lif.load_valid = 1'b0;
        n_checks++;
        if (lif.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pending_full: got %b want 0", lif.load_ready);
        end
        wait_pos(6*FR + 2*T + B + 1);
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({lif.load_ready, pins} !== {1'b1, 1'b0, 4'hF, 8'hFF}) begin
            n_fail++;
            $display("FAIL rst_midscan: got %h want %h",
                     {lif.load_ready, pins}, {1'b1, 1'b0, 4'hF, 8'hFF});
        end
        rst_n = 1'b1;
        pos = -1;
        for (int i = 0; i < 2*FR; i++) begin
            tick();
            n_checks++;
            if ({lif.load_ready, pins} !== {1'b1, exp_pins(pos, 32'h0, 4'hF)}) begin
                n_fail++;
                $display("FAIL post_rst_dark pos %0d: got %h want %h", pos,
                         {lif.load_ready, pins}, {1'b1, exp_pins(pos, 32'h0, 4'hF)});
            end
        end
    endtask

`ifdef SEVSEG_DIM_EN
    task automatic test_dim();
        drive_load(16'h4321, 4'h0, 4'h0);
        tick();
        lif.load_valid = 1'b0;
        wait_pos(3*FR - 2);
        bright = 4'd8;
        wait_pos(3*FR - 1);
        for (int i = 0; i < FR; i++) begin
            tick();
            n_checks++;
            if (pins !== exp_pins(pos, 32'h99B0A4F9, 4'h0)) begin
                n_fail++;
                $display("FAIL dim_half pos %0d: got %h want %h", pos, pins,
                         exp_pins(pos, 32'h99B0A4F9, 4'h0));
            end
        end
        bright = 4'd0;
        for (int i = 0; i < FR; i++) begin
            tick();
            n_checks++;
            if (pins !== exp_pins(pos, 32'h99B0A4F9, 4'h0)) begin
                n_fail++;
                $display("FAIL dim_zero pos %0d: got %h want %h", pos, pins,
                         exp_pins(pos, 32'h99B0A4F9, 4'h0));
            end
        end
    endtask
`endif

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        pos            = 0;
        bright         = 4'd15;
        rst_n          = 1'b0;
        lif.value_in   = '0;
        lif.dp_in      = '0;
        lif.blank_in   = '0;
        lif.load_valid = 1'b0;
        test_reset();
        test_load();
        test_midframe();
        test_blank_dp();
        test_reset_midscan();
`ifdef SEVSEG_DIM_EN
        test_dim();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
